// File: rtl/uart_pkg.sv
// Shared definitions for the serial debug transmit path: byte width,
// default transmitter busy timeout and the arbiter state encoding.
package uart_pkg;

    localparam int BYTE_W               = 8;
    localparam int DEFAULT_BUSY_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1,
        WAIT_HI = 2'd2
    } tx_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping past N_REQ-1 back to 0.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int             pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        onehot  = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            pos_idx = pos[IDX_W-1:0];
            if (!any && req[pos_idx]) begin
                any             = 1'b1;
                idx             = pos_idx;
                onehot[pos_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte producers with round-robin
// arbitration and packet lock; hides the vld_tx/rdy_tx handshake.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_vld,
    input  logic [N_REQ-1:0]      req_last,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]      req_rdy,
    output logic [N_REQ-1:0]      grant,
    output logic [BYTE_W-1:0]     d_tx,
    output logic                  vld_tx,
    input  logic                  rdy_tx,
    output logic                  busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;

    tx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lock_q, lock_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [BYTE_W-1:0]  d_tx_q, d_tx_d;
    logic               vld_tx_q, vld_tx_d;

    logic [BYTE_W-1:0]  data_arr [N_REQ];
    logic [N_REQ-1:0]   owner_mask;
    logic [N_REQ-1:0]   elig;
    logic [N_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_data
        assign data_arr[gi] = req_data[gi*BYTE_W +: BYTE_W];
    end

    // While a packet is open only its owner may compete.
    assign owner_mask = lock_q ? (N_REQ'(1) << owner_q) : '0;
    assign elig       = lock_q ? (req_vld & owner_mask) : req_vld;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (elig),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lock_d   = lock_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        d_tx_d   = d_tx_q;
        vld_tx_d = 1'b0;
        req_rdy  = '0;
        case (state_q)
            IDLE: begin
                if (rdy_tx && pick_any) begin
                    req_rdy  = pick_onehot;
                    d_tx_d   = data_arr[pick_idx];
                    vld_tx_d = 1'b1;
                    state_d  = WAIT_LO;
                    if (req_last[pick_idx]) begin
                        lock_d = 1'b0;
                        ptr_d  = (pick_idx == IDX_W'(N_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
                    end else begin
                        lock_d  = 1'b1;
                        owner_d = pick_idx;
                    end
                end
            end
            WAIT_LO: begin
                // A transmitter that never reports busy is treated as having taken the byte.
                if (!rdy_tx || cnt_q == CNT_W'(BUSY_TIMEOUT-1)) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (rdy_tx) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lock_q   <= 1'b0;
            owner_q  <= '0;
            ptr_q    <= '0;
            d_tx_q   <= '0;
            vld_tx_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            d_tx_q   <= d_tx_d;
            vld_tx_q <= vld_tx_d;
        end
    end

    assign grant  = owner_mask;
    assign d_tx   = d_tx_q;
    assign vld_tx = vld_tx_q;
    assign busy   = (state_q != IDLE);

endmodule
